// File: rtl/obi_arbiter_2_to_1_if.sv
// -----------------------------------------------------------------------------
// obi_arbiter_2_to_1_if
// One OBI channel: the address phase (req/gnt/addr/we/be/wdata) and the
// response phase (rvalid/rdata), all 32-bit address and data.
//
// Modports
//   master : the side that issues requests (a controller, or the arbiter's
//            shared target-facing port)
//   slave  : the side that grants and responds (a target, or the arbiter's
//            controller-facing ports)
// -----------------------------------------------------------------------------
interface obi_arbiter_2_to_1_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/obi_arbiter_2_to_1.sv
// -----------------------------------------------------------------------------
// obi_arbiter_2_to_1
// Round-robin arbiter that lets two OBI controllers share one OBI target port.
// Only one transaction is in flight at a time. The controller that won the
// address phase owns the response phase, and a response timeout answers with
// 32'hDEAD_BEEF so a dead target cannot hang a controller.
//
// Parameters
//   RESP_TIMEOUT : cycles spent waiting for rvalid before a forced response
//                  (0 disables the timeout)
//
// Ports
//   clk_i     : clock, all state changes on the rising edge
//   rst_i     : synchronous active-high reset; forces every output to 0
//   ctrl0     : controller 0 (slave modport)
//   ctrl1     : controller 1 (slave modport)
//   port      : shared target port (master modport)
//   timeout_o : one-cycle pulse when a forced timeout response is issued
// -----------------------------------------------------------------------------
module obi_arbiter_2_to_1 #(
    parameter int unsigned RESP_TIMEOUT = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    obi_arbiter_2_to_1_if.slave          ctrl0,
    obi_arbiter_2_to_1_if.slave          ctrl1,
    obi_arbiter_2_to_1_if.master         port,
    output logic                         timeout_o
);

    // A zero timeout still needs a legal one-bit counter.
    localparam int TMO_W    = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;
    localparam int TMO_LAST = (RESP_TIMEOUT > 0) ? int'(RESP_TIMEOUT) - 1 : 0;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_LAST);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RESP
    } state_t;

    state_t           state, state_next;
    logic             owner, owner_next;
    logic             last_gnt, last_gnt_next;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_next;

    logic sel;
    logic sel_req;
    logic expire;

    // Selection: in IDLE the round-robin pointer only matters when both
    // controllers ask at once; once a controller has been picked it stays
    // selected (locked) through ADDR and RESP.
    always_comb begin
        sel = owner;
        if (state == IDLE) begin
            if (ctrl0.req && ctrl1.req) begin
                sel = ~last_gnt;
            end else begin
                sel = ctrl1.req;
            end
        end
        sel_req = sel ? ctrl1.req : ctrl0.req;
        expire  = (RESP_TIMEOUT != 0) && (state == RESP) && !port.rvalid
                  && (tmo_cnt == TMO_MAX);
    end

    // Output muxing. The address path is combinational so a zero-wait target
    // sees the request in the same cycle; a real rvalid on the expiry cycle
    // takes priority over the forced response.
    always_comb begin
        port.req     = 1'b0;
        port.addr    = '0;
        port.we      = 1'b0;
        port.be      = '0;
        port.wdata   = '0;
        ctrl0.gnt    = 1'b0;
        ctrl1.gnt    = 1'b0;
        ctrl0.rvalid = 1'b0;
        ctrl1.rvalid = 1'b0;
        ctrl0.rdata  = '0;
        ctrl1.rdata  = '0;
        timeout_o    = 1'b0;
        if (!rst_i) begin
            port.addr  = sel ? ctrl1.addr  : ctrl0.addr;
            port.we    = sel ? ctrl1.we    : ctrl0.we;
            port.be    = sel ? ctrl1.be    : ctrl0.be;
            port.wdata = sel ? ctrl1.wdata : ctrl0.wdata;
            if (state != RESP) begin
                port.req = sel_req;
                if (sel) begin
                    ctrl1.gnt = port.gnt;
                end else begin
                    ctrl0.gnt = port.gnt;
                end
            end else begin
                timeout_o = expire;
                if (sel) begin
                    ctrl1.rvalid = port.rvalid || expire;
                    ctrl1.rdata  = expire ? TIMEOUT_DATA : port.rdata;
                end else begin
                    ctrl0.rvalid = port.rvalid || expire;
                    ctrl0.rdata  = expire ? TIMEOUT_DATA : port.rdata;
                end
            end
        end
    end

    // Next-state logic. The round-robin pointer only moves on an actual grant,
    // so a controller that abandons its request in ADDR does not lose its turn.
    always_comb begin
        state_next    = state;
        owner_next    = owner;
        last_gnt_next = last_gnt;
        tmo_cnt_next  = tmo_cnt;
        case (state)
            IDLE: begin
                if (sel_req) begin
                    owner_next = sel;
                    if (port.gnt) begin
                        state_next    = RESP;
                        last_gnt_next = sel;
                        tmo_cnt_next  = '0;
                    end else begin
                        state_next = ADDR;
                    end
                end
            end
            ADDR: begin
                if (!sel_req) begin
                    state_next = IDLE;
                end else if (port.gnt) begin
                    state_next    = RESP;
                    last_gnt_next = owner;
                    tmo_cnt_next  = '0;
                end
            end
            RESP: begin
                if (port.rvalid || expire) begin
                    state_next = IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt + TMO_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset prefers controller 0 for the first arbitration.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            last_gnt <= last_gnt_next;
            tmo_cnt  <= tmo_cnt_next;
        end
    end

endmodule

// File: tb/tb_obi_arbiter_2_to_1.sv
// -----------------------------------------------------------------------------
// tb_obi_arbiter_2_to_1
// Directed scenarios with literal expectations followed by a randomized phase.
// A transaction-level model (waiting-for-response counter, locked controller,
// preferred controller) predicts every output on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_obi_arbiter_2_to_1;

    localparam int unsigned RESP_TIMEOUT = 8;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    logic clk_i = 1'b0;
    logic rst_i;
    logic timeout;

    obi_arbiter_2_to_1_if c0 ();
    obi_arbiter_2_to_1_if c1 ();
    obi_arbiter_2_to_1_if pt ();

    obi_arbiter_2_to_1 #(
        .RESP_TIMEOUT(RESP_TIMEOUT)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ctrl0    (c0),
        .ctrl1    (c1),
        .port     (pt),
        .timeout_o(timeout)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Model state: -1 means "not waiting for a response" / "nothing locked".
    int wait_cycles = -1;
    int resp_owner  = 0;
    int locked      = -1;
    int prefer      = 0;

    int n_wait, n_owner, n_locked, n_prefer, c;
    bit fire;
    logic        m_req[2];
    logic [31:0] m_addr[2];
    logic        m_we[2];
    logic [3:0]  m_be[2];
    logic [31:0] m_wdata[2];
    logic        e_gnt[2];
    logic        e_rvalid[2];
    logic [31:0] e_rdata[2];
    logic        e_port_req, e_we, e_timeout;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;

    // Predict all outputs from the current inputs, compare, then advance the
    // model by the clock edge that follows.
    always @(negedge clk_i) begin
        m_req[0] = c0.req;   m_req[1] = c1.req;
        m_addr[0] = c0.addr; m_addr[1] = c1.addr;
        m_we[0] = c0.we;     m_we[1] = c1.we;
        m_be[0] = c0.be;     m_be[1] = c1.be;
        m_wdata[0] = c0.wdata; m_wdata[1] = c1.wdata;
        for (int i = 0; i < 2; i++) begin
            e_gnt[i] = 1'b0; e_rvalid[i] = 1'b0; e_rdata[i] = '0;
        end
        e_port_req = 1'b0; e_addr = '0; e_we = 1'b0; e_be = '0; e_wdata = '0;
        e_timeout = 1'b0;
        n_wait = wait_cycles; n_owner = resp_owner; n_locked = locked; n_prefer = prefer;

        if (rst_i) begin
            n_wait = -1; n_locked = -1; n_prefer = 0;
        end else if (wait_cycles >= 0) begin
            c = resp_owner;
            e_addr = m_addr[c]; e_we = m_we[c]; e_be = m_be[c]; e_wdata = m_wdata[c];
            fire = (RESP_TIMEOUT != 0) && (wait_cycles + 1 == int'(RESP_TIMEOUT)) && !pt.rvalid;
            e_rvalid[c] = pt.rvalid || fire;
            e_rdata[c]  = fire ? TIMEOUT_DATA : pt.rdata;
            e_timeout   = fire;
            n_wait = (pt.rvalid || fire) ? -1 : wait_cycles + 1;
        end else begin
            if (locked >= 0)               c = locked;
            else if (m_req[0] && m_req[1]) c = prefer;
            else if (m_req[1])             c = 1;
            else                           c = 0;
            e_addr = m_addr[c]; e_we = m_we[c]; e_be = m_be[c]; e_wdata = m_wdata[c];
            e_port_req = m_req[c];
            e_gnt[c] = pt.gnt;
            if (locked >= 0 && !m_req[c]) begin
                n_locked = -1;
            end else if (m_req[c]) begin
                if (pt.gnt) begin
                    n_wait = 0; n_owner = c; n_prefer = 1 - c; n_locked = -1;
                end else begin
                    n_locked = c;
                end
            end
        end

        check_output("gnt0",       32'(c0.gnt),    32'(e_gnt[0]));
        check_output("gnt1",       32'(c1.gnt),    32'(e_gnt[1]));
        check_output("rvalid0",    32'(c0.rvalid), 32'(e_rvalid[0]));
        check_output("rvalid1",    32'(c1.rvalid), 32'(e_rvalid[1]));
        check_output("rdata0",     c0.rdata,       e_rdata[0]);
        check_output("rdata1",     c1.rdata,       e_rdata[1]);
        check_output("port_req",   32'(pt.req),    32'(e_port_req));
        check_output("port_addr",  pt.addr,        e_addr);
        check_output("port_we",    32'(pt.we),     32'(e_we));
        check_output("port_be",    32'(pt.be),     32'(e_be));
        check_output("port_wdata", pt.wdata,       e_wdata);
        check_output("timeout",    32'(timeout),   32'(e_timeout));

        wait_cycles = n_wait; resp_owner = n_owner; locked = n_locked; prefer = n_prefer;
    end

    // Drive one cycle of control inputs just after the rising edge, then
    // return shortly after the falling edge so literal checks and field
    // updates stay clear of both edges.
    task automatic apply_stimulus(input logic rst, input logic r0, input logic r1,
                                  input logic g, input logic rv, input logic [31:0] rd);
        @(posedge clk_i);
        #1;
        rst_i = rst; c0.req = r0; c1.req = r1;
        pt.gnt = g; pt.rvalid = rv; pt.rdata = rd;
        @(negedge clk_i);
        #2;
    endtask

    initial begin
        rst_i = 1'b1;
        c0.req = 1'b1; c0.addr = 32'h0000_0100; c0.we = 1'b0; c0.be = 4'h0; c0.wdata = '0;
        c1.req = 1'b1; c1.addr = 32'h0000_0200; c1.we = 1'b0; c1.be = 4'h0; c1.wdata = '0;
        pt.gnt = 1'b1; pt.rvalid = 1'b0; pt.rdata = '0;

        // Reset held three cycles with both controllers requesting.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 1, 1, 1, 0, 0);
            check_output("rst_gnt0", 32'(c0.gnt), 0);
            check_output("rst_port_req", 32'(pt.req), 0);
        end

        // Both read: ctrl0 wins first, ctrl1 next, then ctrl0 again.
        apply_stimulus(0, 1, 1, 1, 0, 0);
        check_output("first_gnt0", 32'(c0.gnt), 1);
        check_output("first_gnt1", 32'(c1.gnt), 0);
        apply_stimulus(0, 0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0, 1, 32'h1234_5678);
        check_output("rd_rvalid0", 32'(c0.rvalid), 1);
        check_output("rd_rdata0", c0.rdata, 32'h1234_5678);
        check_output("rd_rvalid1", 32'(c1.rvalid), 0);
        apply_stimulus(0, 0, 1, 1, 0, 0);
        check_output("rr_gnt1", 32'(c1.gnt), 1);
        apply_stimulus(0, 1, 1, 0, 1, 32'hCAFE_0001);
        check_output("rr_rvalid1", 32'(c1.rvalid), 1);
        check_output("rr_rdata1", c1.rdata, 32'hCAFE_0001);
        apply_stimulus(0, 1, 1, 1, 0, 0);
        check_output("rr_back_gnt0", 32'(c0.gnt), 1);
        check_output("rr_back_gnt1", 32'(c1.gnt), 0);
        apply_stimulus(0, 0, 0, 0, 1, 32'h0000_0055);

        // ctrl1 locks the port while the target stalls; ctrl0 must wait.
        c1.addr = 32'h1000_0004;
        apply_stimulus(0, 0, 1, 0, 0, 0);
        check_output("lock_addr0", pt.addr, 32'h1000_0004);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(0, 1, 1, 0, 0, 0);
            check_output("lock_addr", pt.addr, 32'h1000_0004);
            check_output("lock_req", 32'(pt.req), 1);
        end
        apply_stimulus(0, 1, 1, 1, 0, 0);
        check_output("lock_gnt1", 32'(c1.gnt), 1);
        check_output("lock_gnt0", 32'(c0.gnt), 0);
        apply_stimulus(0, 1, 0, 1, 0, 0);
        check_output("lock_resp_gnt0", 32'(c0.gnt), 0);
        apply_stimulus(0, 1, 0, 1, 1, 32'hBEEF_0002);
        check_output("lock_rvalid1", 32'(c1.rvalid), 1);
        check_output("lock_exit_gnt0", 32'(c0.gnt), 0);
        apply_stimulus(0, 1, 0, 1, 0, 0);
        check_output("after_lock_gnt0", 32'(c0.gnt), 1);
        apply_stimulus(0, 0, 0, 0, 1, 0);

        // Timeout: granted, no response for eight RESP cycles.
        apply_stimulus(0, 1, 0, 1, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0);
            check_output("tmo_early", 32'(timeout), 0);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("tmo_rvalid0", 32'(c0.rvalid), 1);
        check_output("tmo_rdata0", c0.rdata, 32'hDEAD_BEEF);
        check_output("tmo_pulse", 32'(timeout), 1);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("tmo_pulse_end", 32'(timeout), 0);
        apply_stimulus(0, 0, 0, 0, 1, 32'h0000_0077);
        check_output("stray_rvalid0", 32'(c0.rvalid), 0);
        check_output("stray_rvalid1", 32'(c1.rvalid), 0);

        // Write from ctrl0; ctrl1 blocked until the response.
        c0.addr = 32'h2000_0000; c0.we = 1'b1; c0.be = 4'hF; c0.wdata = 32'hA5A5_A5A5;
        apply_stimulus(0, 1, 0, 1, 0, 0);
        check_output("wr_we", 32'(pt.we), 1);
        check_output("wr_be", 32'(pt.be), 32'hF);
        check_output("wr_wdata", pt.wdata, 32'hA5A5_A5A5);
        check_output("wr_gnt0", 32'(c0.gnt), 1);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(0, 0, 1, 1, 0, 0);
            check_output("wr_block_gnt1", 32'(c1.gnt), 0);
            check_output("wr_hold_wdata", pt.wdata, 32'hA5A5_A5A5);
        end
        apply_stimulus(0, 0, 1, 1, 1, 0);
        check_output("wr_rvalid0", 32'(c0.rvalid), 1);
        check_output("wr_exit_gnt1", 32'(c1.gnt), 0);
        apply_stimulus(0, 0, 1, 1, 0, 0);
        check_output("wr_after_gnt1", 32'(c1.gnt), 1);
        apply_stimulus(0, 0, 0, 0, 1, 0);
        c0.addr = 32'h0000_0100; c0.we = 1'b0; c0.be = 4'h0; c0.wdata = '0;

        // Reset in the middle of a response.
        apply_stimulus(0, 1, 0, 1, 0, 0);
        check_output("mid_gnt0", 32'(c0.gnt), 1);
        apply_stimulus(1, 1, 1, 1, 0, 0);
        check_output("mid_rst_gnt0", 32'(c0.gnt), 0);
        apply_stimulus(0, 1, 1, 0, 1, 32'h0000_0099);
        check_output("mid_late_rvalid0", 32'(c0.rvalid), 0);
        check_output("mid_port_addr", pt.addr, 32'h0000_0100);
        apply_stimulus(0, 1, 1, 1, 0, 0);
        check_output("mid_next_gnt0", 32'(c0.gnt), 1);
        check_output("mid_next_gnt1", 32'(c1.gnt), 0);
        apply_stimulus(0, 0, 0, 0, 1, 0);

        // Randomized traffic checked by the model alone.
        for (int i = 0; i < 2000; i++) begin
            apply_stimulus(($urandom_range(0, 63) == 0),
                           ($urandom_range(0, 2) != 0),
                           ($urandom_range(0, 2) != 0),
                           1'($urandom_range(0, 1)),
                           ($urandom_range(0, 3) == 0),
                           $urandom);
            c0.addr = $urandom; c0.we = 1'($urandom_range(0, 1));
            c0.be = 4'($urandom_range(0, 15)); c0.wdata = $urandom;
            c1.addr = $urandom; c1.we = 1'($urandom_range(0, 1));
            c1.be = 4'($urandom_range(0, 15)); c1.wdata = $urandom;
        end

        @(posedge clk_i);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
